// File: rtl/gpp_pkt_filter.sv
// GPP input stage: store-and-forward packet buffer. Kept packets are committed and forwarded,
// invalid / overflowed / malformed packets are discarded by rolling wr_ptr back to commit_ptr.
// state  | meaning
// W_IDLE | waiting for a head beat
// W_PKT  | storing beats of the current packet
// W_DROP | discarding beats up to the tail
// R_IDLE | waiting for a committed packet and downstream room
// R_PKT  | streaming one committed packet, one beat per cycle
module gpp_pkt_filter #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int ALF_THRESH = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mux2gpp_data_wr,
  input  logic [133:0] mux2gpp_data,
  input  logic         mux2gpp_data_valid,
  input  logic         mux2gpp_data_valid_wr,
  output logic         gpp2mux_data_alf,
  output logic         gpp2nxt_data_wr,
  output logic [133:0] gpp2nxt_data,
  output logic         gpp2nxt_data_valid,
  output logic         gpp2nxt_data_valid_wr,
  input  logic         nxt2gpp_data_alf,
  output logic [31:0]  gpp_fwd_cnt,
  output logic [31:0]  gpp_drop_cnt
);

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_PKT} rstate_t;

  logic [133:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
  wstate_t      r_wstate;
  rstate_t      r_rstate;
  logic [133:0] r_ram_q;
  logic         r_ram_vld;
  logic         r_out_wr, r_out_vwr, r_alf;
  logic [133:0] r_out_data;
  logic [31:0]  r_fwd_cnt, r_drop_cnt;

  logic          w_head, w_tail, w_keep, w_full, w_commit_full, w_rd_tail;
  logic [AW:0]   w_used, w_commit_used;
  logic [AW+1:0] w_free;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;

  assign w_head        = (mux2gpp_data[133:132] == HDR_HEAD);
  assign w_tail        = (mux2gpp_data[133:132] == HDR_TAIL);
  assign w_keep        = mux2gpp_data_valid_wr & mux2gpp_data_valid;
  assign w_used        = r_wr_ptr - r_rd_ptr;
  assign w_commit_used = r_commit_ptr - r_rd_ptr;
  assign w_full        = (w_used == (AW+1)'(DEPTH));
  assign w_commit_full = (w_commit_used == (AW+1)'(DEPTH));
  assign w_free        = (AW+2)'(DEPTH) - {1'b0, w_used};
  assign w_rd_tail     = (r_ram_q[133:132] == HDR_TAIL);

  // A malformed head restarts the packet at commit_ptr, so it is written there.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_wr_ptr[AW-1:0];
    if (mux2gpp_data_wr) begin
      case (r_wstate)
        W_IDLE: w_mem_we = w_head && !w_full;
        W_PKT: begin
          if (w_head) begin
            w_mem_we    = !w_commit_full;
            w_mem_waddr = r_commit_ptr[AW-1:0];
          end else begin
            w_mem_we = !w_full;
          end
        end
        default: w_mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= mux2gpp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate     <= W_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_drop_cnt   <= '0;
    end else if (mux2gpp_data_wr) begin
      case (r_wstate)
        W_IDLE: begin
          if (w_head) begin
            if (w_full) begin
              r_wstate <= W_DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_wstate <= W_PKT;
            end
          end
        end
        W_PKT: begin
          if (w_head) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
            if (w_commit_full) begin
              r_wr_ptr <= r_commit_ptr;
              r_wstate <= W_DROP;
            end else begin
              r_wr_ptr <= r_commit_ptr + 1'b1;
            end
          end else if (w_tail) begin
            if (w_keep && !w_full) begin
              r_wr_ptr     <= r_wr_ptr + 1'b1;
              r_commit_ptr <= r_wr_ptr + 1'b1;
            end else begin
              r_wr_ptr   <= r_commit_ptr;
              r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            r_wstate <= W_IDLE;
          end else if (w_full) begin
            r_wstate <= W_DROP;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
        W_DROP: begin
          if (w_tail) begin
            r_wr_ptr   <= r_commit_ptr;
            r_drop_cnt <= r_drop_cnt + 32'd1;
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Next read is issued while the previous beat sits in r_ram_q, so reading stops right at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate   <= R_IDLE;
      r_rd_ptr   <= '0;
      r_ram_q    <= '0;
      r_ram_vld  <= 1'b0;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_vwr  <= 1'b0;
      r_fwd_cnt  <= '0;
      r_alf      <= 1'b0;
    end else begin
      r_alf     <= (w_free < (AW+2)'(ALF_THRESH));
      r_out_wr  <= r_ram_vld;
      r_out_data <= r_ram_vld ? r_ram_q : '0;
      r_out_vwr <= r_ram_vld && w_rd_tail;
      if (r_ram_vld && w_rd_tail) r_fwd_cnt <= r_fwd_cnt + 32'd1;
      case (r_rstate)
        R_IDLE: begin
          if ((r_rd_ptr != r_commit_ptr) && !nxt2gpp_data_alf) begin
            r_ram_q   <= r_mem[r_rd_ptr[AW-1:0]];
            r_ram_vld <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rstate  <= R_PKT;
          end else begin
            r_ram_vld <= 1'b0;
          end
        end
        R_PKT: begin
          if (w_rd_tail) begin
            r_ram_vld <= 1'b0;
            r_rstate  <= R_IDLE;
          end else begin
            r_ram_q   <= r_mem[r_rd_ptr[AW-1:0]];
            r_ram_vld <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign gpp2mux_data_alf      = r_alf;
  assign gpp2nxt_data_wr       = r_out_wr;
  assign gpp2nxt_data          = r_out_data;
  assign gpp2nxt_data_valid    = r_out_vwr;
  assign gpp2nxt_data_valid_wr = r_out_vwr;
  assign gpp_fwd_cnt           = r_fwd_cnt;
  assign gpp_drop_cnt          = r_drop_cnt;

endmodule

// File: tb/tb_gpp_pkt_filter.sv
// Directed bench for gpp_pkt_filter: packet streams with hand-derived expected beats and counts.
module tb_gpp_pkt_filter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mux2gpp_data_wr = 1'b0;
  logic [133:0] mux2gpp_data = '0;
  logic         mux2gpp_data_valid = 1'b0;
  logic         mux2gpp_data_valid_wr = 1'b0;
  logic         gpp2mux_data_alf;
  logic         gpp2nxt_data_wr;
  logic [133:0] gpp2nxt_data;
  logic         gpp2nxt_data_valid;
  logic         gpp2nxt_data_valid_wr;
  logic         nxt2gpp_data_alf = 1'b0;
  logic [31:0]  gpp_fwd_cnt;
  logic [31:0]  gpp_drop_cnt;

  gpp_pkt_filter dut (
    .clk(clk), .rst_n(rst_n),
    .mux2gpp_data_wr(mux2gpp_data_wr), .mux2gpp_data(mux2gpp_data),
    .mux2gpp_data_valid(mux2gpp_data_valid), .mux2gpp_data_valid_wr(mux2gpp_data_valid_wr),
    .gpp2mux_data_alf(gpp2mux_data_alf),
    .gpp2nxt_data_wr(gpp2nxt_data_wr), .gpp2nxt_data(gpp2nxt_data),
    .gpp2nxt_data_valid(gpp2nxt_data_valid), .gpp2nxt_data_valid_wr(gpp2nxt_data_valid_wr),
    .nxt2gpp_data_alf(nxt2gpp_data_alf),
    .gpp_fwd_cnt(gpp_fwd_cnt), .gpp_drop_cnt(gpp_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0] exp_q[$];
  logic [133:0] cap_d[$];
  logic         cap_vwr[$];
  logic         cap_v[$];
  int           cap_cyc[$];

  always @(negedge clk) begin
    if (gpp2nxt_data_wr) begin
      cap_d.push_back(gpp2nxt_data);
      cap_vwr.push_back(gpp2nxt_data_valid_wr);
      cap_v.push_back(gpp2nxt_data_valid);
      cap_cyc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int tail_cyc = 0;

  function automatic logic [133:0] mk_beat(input logic [1:0] h, input int id, input int i);
    return {h, 100'(id), 32'(i)};
  endfunction

  task automatic send_beat(input logic [133:0] d, input logic vwr, input logic v);
    @(posedge clk); #1;
    mux2gpp_data_wr       = 1'b1;
    mux2gpp_data          = d;
    mux2gpp_data_valid_wr = vwr;
    mux2gpp_data_valid    = vwr & v;
    if (d[133:132] == 2'b10) tail_cyc = cyc + 1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mux2gpp_data_wr       = 1'b0;
    mux2gpp_data_valid_wr = 1'b0;
    mux2gpp_data_valid    = 1'b0;
  endtask

  task automatic send_pkt(input int id, input int n, input logic v, input bit push);
    logic [1:0]   h;
    logic [133:0] d;
    for (int i = 0; i < n; i++) begin
      h = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
      d = mk_beat(h, id, i);
      send_beat(d, (i == n - 1), v);
      if (push) exp_q.push_back(d);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cap_d.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete(); cap_d.delete(); cap_vwr.delete(); cap_v.delete(); cap_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({gpp2nxt_data_wr, gpp2nxt_data_valid, gpp2nxt_data_valid_wr, gpp2mux_data_alf} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000",
        {gpp2nxt_data_wr, gpp2nxt_data_valid, gpp2nxt_data_valid_wr, gpp2mux_data_alf});
    end
    n_cmp++;
    if (gpp2nxt_data !== 134'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", gpp2nxt_data); end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'd0 || gpp_drop_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got fwd=%0d drop=%0d want 0/0", gpp_fwd_cnt, gpp_drop_cnt);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    send_pkt(1, 4, 1'b1, 1'b1);
    idle();
    exp_fwd++;
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 4) begin
      n_fail++; $display("FAIL single_beats: got %0d beats want 4", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i])
        if (cap_d[i] !== exp_q[i] || cap_vwr[i] !== (i == 3) || cap_v[i] !== (i == 3)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL single_data: got %0d bad beats want 0", bad); end
      n_cmp++;
      if (cap_cyc[0] - tail_cyc != 2) begin
        n_fail++; $display("FAIL single_latency: got %0d cycles want 2", cap_cyc[0] - tail_cyc);
      end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd) || gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL single_cnt: got fwd=%0d drop=%0d want %0d/%0d",
        gpp_fwd_cnt, gpp_drop_cnt, exp_fwd, exp_drop);
    end
    clear_q();
  endtask

  task automatic test_drop_valid0();
    bit ok;
    int bad;
    send_pkt(2, 3, 1'b0, 1'b0);
    send_pkt(3, 2, 1'b1, 1'b1);
    idle();
    exp_drop++; exp_fwd++;
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 2) begin
      n_fail++; $display("FAIL drop0_beats: got %0d beats want 2", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i])
        if (cap_d[i] !== exp_q[i] || cap_vwr[i] !== (i == 1)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL drop0_data: got %0d bad beats want 0", bad); end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd) || gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL drop0_cnt: got fwd=%0d drop=%0d want %0d/%0d",
        gpp_fwd_cnt, gpp_drop_cnt, exp_fwd, exp_drop);
    end
    n_cmp++;
    if (dut.r_wr_ptr !== dut.r_rd_ptr) begin
      n_fail++; $display("FAIL drop0_used: got wr=%0d rd=%0d want equal", dut.r_wr_ptr, dut.r_rd_ptr);
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    send_pkt(20, 2, 1'b1, 1'b1);
    send_pkt(21, 2, 1'b1, 1'b1);
    idle();
    exp_fwd += 2;
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 4) begin
      n_fail++; $display("FAIL b2b_beats: got %0d beats want 4", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i])
        if (cap_d[i] !== exp_q[i] || cap_vwr[i] !== (i == 1 || i == 3)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad beats want 0", bad); end
      n_cmp++;
      if (cap_cyc[2] - cap_cyc[1] != 2) begin
        n_fail++; $display("FAIL b2b_gap: got %0d cycles tail-to-head want 2", cap_cyc[2] - cap_cyc[1]);
      end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd)) begin
      n_fail++; $display("FAIL b2b_fwd: got %0d want %0d", gpp_fwd_cnt, exp_fwd);
    end
    clear_q();
  endtask

  task automatic test_alf_overflow();
    bit ok;
    int bad;
    nxt2gpp_data_alf = 1'b1;
    send_pkt(30, 95, 1'b1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (gpp2mux_data_alf !== 1'b0) begin n_fail++; $display("FAIL alf_one_pkt: got %b want 0", gpp2mux_data_alf); end
    send_pkt(31, 95, 1'b1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (gpp2mux_data_alf !== 1'b1) begin n_fail++; $display("FAIL alf_two_pkt: got %b want 1", gpp2mux_data_alf); end
    send_pkt(32, 95, 1'b1, 1'b0);
    idle();
    exp_drop++;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cap_d.size() != 0) begin n_fail++; $display("FAIL alf_hold: got %0d beats out want 0", cap_d.size()); end
    n_cmp++;
    if (gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL alf_ovf_drop: got %0d want %0d", gpp_drop_cnt, exp_drop);
    end
    nxt2gpp_data_alf = 1'b0;
    exp_fwd += 2;
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 190) begin
      n_fail++; $display("FAIL alf_beats: got %0d beats want 190", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i])
        if (cap_d[i] !== exp_q[i] || cap_vwr[i] !== (i == 94 || i == 189)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL alf_data: got %0d bad beats want 0", bad); end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd) || gpp2mux_data_alf !== 1'b0) begin
      n_fail++; $display("FAIL alf_end: got fwd=%0d alf=%b want %0d/0", gpp_fwd_cnt, gpp2mux_data_alf, exp_fwd);
    end
    clear_q();
  endtask

  task automatic test_malformed();
    bit ok;
    int bad;
    send_beat(mk_beat(2'b01, 40, 0), 1'b0, 1'b0);
    send_beat(mk_beat(2'b11, 40, 1), 1'b0, 1'b0);
    send_beat(mk_beat(2'b11, 40, 2), 1'b0, 1'b0);
    send_pkt(41, 2, 1'b1, 1'b1);
    idle();
    exp_drop++; exp_fwd++;
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 2) begin
      n_fail++; $display("FAIL malformed_beats: got %0d beats want 2", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i])
        if (cap_d[i] !== exp_q[i] || cap_vwr[i] !== (i == 1)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL malformed_data: got %0d bad beats want 0", bad); end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd) || gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL malformed_cnt: got fwd=%0d drop=%0d want %0d/%0d",
        gpp_fwd_cnt, gpp_drop_cnt, exp_fwd, exp_drop);
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    send_pkt(50, 8, 1'b1, 1'b0);
    send_beat(mk_beat(2'b01, 51, 0), 1'b0, 1'b0);
    send_beat(mk_beat(2'b11, 51, 1), 1'b0, 1'b0);
    send_beat(mk_beat(2'b11, 51, 2), 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (gpp2nxt_data_wr !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: got wr=%b want 1", gpp2nxt_data_wr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gpp2nxt_data_wr, gpp2nxt_data_valid_wr, gpp2nxt_data_valid, gpp2mux_data_alf} !== 4'b0 ||
        gpp2nxt_data !== 134'd0) begin
      n_fail++; $display("FAIL rstmid_out: got wr=%b data=%h want 0", gpp2nxt_data_wr, gpp2nxt_data);
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'd0 || gpp_drop_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_cnt: got fwd=%0d drop=%0d want 0/0", gpp_fwd_cnt, gpp_drop_cnt);
    end
    mux2gpp_data_wr = 1'b0; mux2gpp_data_valid_wr = 1'b0; mux2gpp_data_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    clear_q();
    exp_fwd = 1; exp_drop = 0;
    send_pkt(52, 3, 1'b1, 1'b1);
    idle();
    wait_drain(ok);
    n_cmp++;
    if (!ok || cap_d.size() != 3) begin
      n_fail++; $display("FAIL rstmid_beats: got %0d beats want 3", cap_d.size());
    end else begin
      bad = 0;
      foreach (exp_q[i]) if (cap_d[i] !== exp_q[i]) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_data: got %0d bad beats want 0", bad); end
    end
    n_cmp++;
    if (gpp_fwd_cnt !== 32'(exp_fwd) || gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL rstmid_after: got fwd=%0d drop=%0d want %0d/%0d",
        gpp_fwd_cnt, gpp_drop_cnt, exp_fwd, exp_drop);
    end
    clear_q();
  endtask

  task automatic test_fwd_wrap();
    bit ok;
    @(negedge clk);
    force dut.r_fwd_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_fwd_cnt;
    send_pkt(60, 2, 1'b1, 1'b1);
    idle();
    wait_drain(ok);
    n_cmp++;
    if (!ok || gpp_fwd_cnt !== 32'd0) begin
      n_fail++; $display("FAIL fwd_wrap: got %h want 00000000", gpp_fwd_cnt);
    end
    n_cmp++;
    if (gpp_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL wrap_drop: got %0d want %0d", gpp_drop_cnt, exp_drop);
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop_valid0();
    test_back_to_back();
    test_alf_overflow();
    test_malformed();
    test_reset_mid();
    test_fwd_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
